// File: rtl/field_mex.sv
// Memory-extension unit: data field, instruction field, instruction buffer and
// interrupt save field, driving the address bits above the 12-bit word address.
module field_mex #(
  parameter int unsigned                FIELD_BITS  = 3,
  parameter logic [FIELD_BITS-1:0]      RESET_FIELD = '0
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [FIELD_BITS-1:0]         dbus,
  input  logic                          df_wr,
  input  logic                          ib_wr,
  input  logic                          wrp,
  input  logic                          intr,
  input  logic                          rmf,
  input  logic                          deref,
  input  logic                          state_load,
  input  logic                          state_exec,
  output logic [FIELD_BITS-1:0]         abus_ext,
  output logic [FIELD_BITS-1:0]         df_out,
  output logic [FIELD_BITS-1:0]         if_out,
  output logic [2*FIELD_BITS-1:0]       sf_out,
  output logic                          int_inhibit
);

  typedef struct packed {
    logic [FIELD_BITS-1:0]   data_f;
    logic [FIELD_BITS-1:0]   instr_f;
    logic [FIELD_BITS-1:0]   ib;
    logic [2*FIELD_BITS-1:0] sf;
    logic                    inhibit;
  } mex_t;

  mex_t cur, nxt;
  logic use_df;

  // Indirect operands fetched in LOAD/EXEC use the data field; everything else
  // (instruction fetch, direct operands) uses the instruction field.
  assign use_df      = deref & (state_load | state_exec);
  assign abus_ext    = use_df ? cur.data_f : cur.instr_f;
  assign df_out      = cur.data_f;
  assign if_out      = cur.instr_f;
  assign sf_out      = cur.sf;
  assign int_inhibit = cur.inhibit;

  always_comb begin
    // NOTE: every field of nxt takes its hold value first, so no path through
    // the priority chain below can leave a field unassigned and infer a latch.
    nxt = cur;
    if (intr) begin
      nxt.sf      = {cur.instr_f, cur.data_f};
      nxt.data_f  = '0;
      nxt.instr_f = '0;
      nxt.ib      = '0;
      nxt.inhibit = 1'b0;
    end else begin
      if (rmf) begin
        nxt.ib      = cur.sf[2*FIELD_BITS-1:FIELD_BITS];
        nxt.data_f  = cur.sf[FIELD_BITS-1:0];
        nxt.inhibit = 1'b1;
      end else begin
        if (df_wr) nxt.data_f = dbus;
        if (ib_wr) begin
          nxt.ib      = dbus;
          nxt.inhibit = 1'b1;
        end
      end
      // The jump takes the buffer value as updated this cycle, so a CIF or
      // RMF coinciding with the PC write lands in IF at once.
      if (wrp) begin
        nxt.instr_f = nxt.ib;
        nxt.inhibit = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur.data_f  <= RESET_FIELD;
      cur.instr_f <= RESET_FIELD;
      cur.ib      <= RESET_FIELD;
      cur.sf      <= '0;
      cur.inhibit <= 1'b0;
    end else begin
      cur <= nxt;
    end
  end

endmodule
